// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the scoreboard display scheduler:
//   disp_state_t : scheduler states (IDLE, SHOW_SCORE, SHOW_TIMER, FLASH)
//   MODE_*       : encodings of the 2-bit mode input
//   BLANK_DIGIT  : BCD code the scanner treats as a dark digit
// ---------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SHOW_SCORE = 2'd1,
      SHOW_TIMER = 2'd2,
      FLASH      = 2'd3
   } disp_state_t;

   localparam logic [1:0] MODE_AUTO  = 2'b00;
   localparam logic [1:0] MODE_SCORE = 2'b01;
   localparam logic [1:0] MODE_TIMER = 2'b10;
   localparam logic [1:0] MODE_BLANK = 2'b11;

   localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/disp_scheduler_scan_divider.sv
// ---------------------------------------------------------------------------
// scan_divider
// Divides clk_in down to the digit-scan rate and walks the digit index.
// Ports:
//   clk_in, rst_n (sync, active-low), en (0 freezes everything)
//   scan_tick : registered 1-cycle pulse every SCAN_DIV enabled cycles
//   dig_sel   : digit slot 0..3, advances on each scan_tick
//   frame_end : scan_tick while dig_sel==3 (last slot of a frame)
// ---------------------------------------------------------------------------
module scan_divider #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       en,
   output logic       scan_tick,
   output logic [1:0] dig_sel,
   output logic       frame_end
);

   localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div_cnt;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         scan_tick <= 1'b0;
         dig_sel   <= 2'd0;
      end else if (en) begin
         div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         scan_tick <= (div_cnt == DIV_LAST);
         if (scan_tick) dig_sel <= dig_sel + 2'd1;
      end else begin
         // A tick pending while frozen is dropped, never stretched.
         scan_tick <= 1'b0;
      end
   end

   assign frame_end = scan_tick && (dig_sel == 2'd3);

endmodule

// File: rtl/disp_scheduler.sv
// ---------------------------------------------------------------------------
// disp_scheduler
// Chooses what the shared 4-digit 7-segment display shows: game score or
// game timer, rotating in auto mode and flashing the score when it changes.
// Source switches happen only at frame boundaries so a frame never tears.
// Ports:
//   clk_in, rst_n (sync, active-low), en (0 freezes divider/counters/state)
//   mode      : 00 auto, 01 score only, 10 timer only, 11 blank
//   score     : BCD score, score_vld pulses when it holds a new value
//   timer     : BCD timer value
//   disp_num  : BCD word to the scanner
//   blank     : 1 = all digits dark
//   src       : 0 = score shown, 1 = timer shown
//   scan_tick : digit-slot strobe, dig_sel : current digit slot
// ---------------------------------------------------------------------------
module disp_scheduler
   import disp_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int DWELL_TICKS = 2000,
   parameter int FLASH_TICKS = 1000,
   parameter int BLINK_TICKS = 250
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [15:0] score,
   input  logic        score_vld,
   input  logic [15:0] timer,
   output logic [15:0] disp_num,
   output logic        blank,
   output logic        src,
   output logic        scan_tick,
   output logic [1:0]  dig_sel
);

   localparam int TMAX = (DWELL_TICKS > FLASH_TICKS) ? DWELL_TICKS : FLASH_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_TICKS - 1);
   localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   disp_state_t   state, nxt;
   logic [TW-1:0] tick_cnt;
   logic [BW-1:0] blink_cnt;
   logic [15:0]   score_q, score_eff;
   logic          pend, pend_eff, cap;
   logic          frame_end, fe, tk;
   logic          load, restart, flash_start, blink_step;

   scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en),
      .scan_tick (scan_tick),
      .dig_sel   (dig_sel),
      .frame_end (frame_end)
   );

   always_comb begin
      // Score capture is live even while frozen; a capture coinciding with
      // frame_end is seen by that frame_end's decision.
      cap       = score_vld && !mode[1];
      pend_eff  = pend || cap;
      score_eff = cap ? score : score_q;
      tk        = en && scan_tick;
      fe        = en && frame_end;
      nxt       = state;
      load      = 1'b0;
      restart   = 1'b0;

      if (mode == MODE_BLANK) begin
         nxt  = IDLE;
         load = 1'b1;
      end else if (fe) begin
         load = 1'b1;
         case (state)
            IDLE: begin
               if (pend_eff)                nxt = FLASH;
               else if (mode == MODE_TIMER) nxt = SHOW_TIMER;
               else                         nxt = SHOW_SCORE;
            end
            SHOW_SCORE, SHOW_TIMER: begin
               if (pend_eff && mode != MODE_TIMER) nxt = FLASH;
               else if (mode == MODE_SCORE)        nxt = SHOW_SCORE;
               else if (mode == MODE_TIMER)        nxt = SHOW_TIMER;
               else if (tick_cnt == DWELL_LAST)
                  nxt = (state == SHOW_SCORE) ? SHOW_TIMER : SHOW_SCORE;
            end
            FLASH: begin
               if (pend_eff)                   restart = 1'b1;
               else if (tick_cnt >= FLASH_LAST)
                  nxt = (mode == MODE_TIMER) ? SHOW_TIMER : SHOW_SCORE;
            end
            default: nxt = IDLE;
         endcase
      end

      flash_start = load && (nxt == FLASH) && ((state != FLASH) || restart);
      blink_step  = tk && (state == FLASH) && (nxt == FLASH) && !flash_start;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         blink_cnt <= '0;
         score_q   <= 16'h0000;
         pend      <= 1'b0;
         disp_num  <= 16'h0000;
         blank     <= 1'b1;
         src       <= 1'b0;
      end else begin
         state   <= nxt;
         score_q <= score_eff;

         if (flash_start) pend <= 1'b0;
         else if (cap)    pend <= 1'b1;

         if ((nxt != state) || restart) tick_cnt <= '0;
         else if (tk)                   tick_cnt <= tick_cnt + 1'b1;

         if (load) begin
            case (nxt)
               IDLE:       begin disp_num <= 16'h0000;  src <= 1'b0; end
               SHOW_TIMER: begin disp_num <= timer;     src <= 1'b1; end
               default:    begin disp_num <= score_eff; src <= 1'b0; end
            endcase
         end

         // Blink phase: blank flips each time BLINK_TICKS ticks have elapsed
         // inside the flash, i.e. whenever tick_cnt reaches a multiple.
         if (flash_start) begin
            blank     <= 1'b0;
            blink_cnt <= '0;
         end else if (load && nxt != FLASH) begin
            blank <= (nxt == IDLE);
         end else if (blink_step) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blank     <= ~blank;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_disp_scheduler.sv
module tb_disp_scheduler;

   localparam int SCAN_DIV    = 4;
   localparam int DWELL_TICKS = 8;
   localparam int FLASH_TICKS = 8;
   localparam int BLINK_TICKS = 2;
   localparam int CNT_MOD     = 8;   // tick counter wraps at its 3-bit width

   localparam int S_IDLE = 0, S_SCORE = 1, S_TIMER = 2, S_FLASH = 3;

   logic        clk_in = 1'b0;
   logic        rst_n, en, score_vld;
   logic [1:0]  mode;
   logic [15:0] score, timer;
   logic [15:0] disp_num;
   logic        blank, src, scan_tick;
   logic [1:0]  dig_sel;

   always #5 clk_in = ~clk_in;

   disp_scheduler #(
      .SCAN_DIV    (SCAN_DIV),
      .DWELL_TICKS (DWELL_TICKS),
      .FLASH_TICKS (FLASH_TICKS),
      .BLINK_TICKS (BLINK_TICKS)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .score     (score),
      .score_vld (score_vld),
      .timer     (timer),
      .disp_num  (disp_num),
      .blank     (blank),
      .src       (src),
      .scan_tick (scan_tick),
      .dig_sel   (dig_sel)
   );

   typedef struct packed {
      logic [15:0] disp;
      logic        blank;
      logic        src;
      logic        tick;
      logic [1:0]  dig;
   } obs_t;

   obs_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Reference model state: active-cycle count, ticks consumed, screen state.
   int          m_ac, m_ticks, m_st, m_cnt;
   bit          m_pend, m_tick;
   logic [15:0] m_sq, m_disp;

   function automatic obs_t model_obs();
      obs_t o;
      o.disp  = m_disp;
      o.src   = (m_st == S_TIMER);
      o.tick  = m_tick;
      o.dig   = 2'(m_ticks % 4);
      case (m_st)
         S_IDLE:  o.blank = 1'b1;
         S_FLASH: o.blank = ((m_cnt / BLINK_TICKS) % 2) == 1;
         default: o.blank = 1'b0;
      endcase
      return o;
   endfunction

   // Predict what the DUT shows after the coming clock edge, given the
   // inputs currently applied, and queue it for the monitor.
   task automatic model_step();
      bit tk, fe, cap, pe, restart, load, start;
      int nst;
      logic [15:0] sq;
      if (!rst_n) begin
         m_ac = 0; m_ticks = 0; m_st = S_IDLE; m_cnt = 0;
         m_pend = 0; m_tick = 0; m_sq = 16'h0; m_disp = 16'h0;
      end else begin
         tk  = en && m_tick;
         fe  = tk && (m_ticks % 4 == 3);
         cap = score_vld && (mode == 2'b00 || mode == 2'b01);
         pe  = m_pend || cap;
         sq  = cap ? score : m_sq;
         nst = m_st; restart = 0; load = 0;
         if (mode == 2'b11) begin
            nst = S_IDLE; load = 1;
         end else if (fe) begin
            load = 1;
            if (m_st == S_IDLE) begin
               nst = pe ? S_FLASH : (mode == 2'b10 ? S_TIMER : S_SCORE);
            end else if (m_st == S_FLASH) begin
               if (pe) restart = 1;
               else if (m_cnt == FLASH_TICKS - 1) nst = (mode == 2'b10) ? S_TIMER : S_SCORE;
            end else begin
               if (pe && mode != 2'b10) nst = S_FLASH;
               else if (mode == 2'b01)  nst = S_SCORE;
               else if (mode == 2'b10)  nst = S_TIMER;
               else if (m_cnt == DWELL_TICKS - 1) nst = (m_st == S_SCORE) ? S_TIMER : S_SCORE;
            end
         end
         start = (nst == S_FLASH) && (m_st != S_FLASH || restart);
         if (nst != m_st || restart) m_cnt = 0;
         else if (tk)                m_cnt = (m_cnt + 1) % CNT_MOD;
         if (start)    m_pend = 0;
         else if (cap) m_pend = 1;
         m_sq = sq;
         if (load) m_disp = (nst == S_IDLE) ? 16'h0 : (nst == S_TIMER) ? timer : sq;
         if (tk) m_ticks++;
         if (en) begin
            m_ac++;
            m_tick = (m_ac % SCAN_DIV) == 0;
         end else begin
            m_tick = 0;
         end
         m_st = nst;
      end
      sb_q.push_back(model_obs());
   endtask

   // Monitor: every edge after which a prediction exists, compare.
   always @(posedge clk_in) begin
      obs_t e, a;
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         a = '{disp: disp_num, blank: blank, src: src, tick: scan_tick, dig: dig_sel};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL sb cyc=%0d got disp=%h blank=%b src=%b tick=%b dig=%0d want disp=%h blank=%b src=%b tick=%b dig=%0d",
                     cyc, a.disp, a.blank, a.src, a.tick, a.dig, e.disp, e.blank, e.src, e.tick, e.dig);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Called at a falling edge; applies current inputs for n cycles.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(posedge clk_in);
         @(negedge clk_in);
      end
   endtask

   task automatic pulse_score(input logic [15:0] v);
      score = v; score_vld = 1'b1;
      run(1);
      score_vld = 1'b0;
   endtask

   task automatic wait_src(input logic want);
      int k = 0;
      while (src !== want && k < 200) begin
         run(1);
         k++;
      end
      chk("wait_src", {31'b0, src}, {31'b0, want});
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 2'b00; score_vld = 1'b0;
      score = 16'h0012; timer = 16'h0459;
      @(negedge clk_in);
      run(3);
      chk("rst_disp",  {16'b0, disp_num}, 32'h0);
      chk("rst_blank", {31'b0, blank}, 32'h1);
      chk("rst_src",   {31'b0, src}, 32'h0);
      chk("rst_tick",  {31'b0, scan_tick}, 32'h0);
      chk("rst_dig",   {30'b0, dig_sel}, 32'h0);

      // Release: fourth tick at edge 16 ends the first frame.
      rst_n = 1'b1;
      run(16);
      chk("e16_tick",  {31'b0, scan_tick}, 32'h1);
      chk("e16_dig",   {30'b0, dig_sel}, 32'h3);
      chk("e16_blank", {31'b0, blank}, 32'h1);
      run(1);
      chk("e17_blank", {31'b0, blank}, 32'h0);
      chk("e17_disp",  {16'b0, disp_num}, 32'h0);
      chk("e17_src",   {31'b0, src}, 32'h0);

      // Auto rotation and mid-frame timer change.
      run(32);
      run(6);
      timer = 16'h0460;
      run(40);

      // Score update while the timer is shown, then a second during flash.
      wait_src(1'b1);
      pulse_score(16'h0015);
      run(60);
      pulse_score(16'h0016);
      run(24);
      pulse_score(16'h0017);
      run(80);

      // Timer-only mode ignores score updates; then blank immediately.
      mode = 2'b10;
      for (int i = 0; i < 3; i++) begin
         pulse_score(16'($urandom));
         run(10);
      end
      run(40);
      run(5);
      mode = 2'b11;
      run(1);
      chk("blank_now", {31'b0, blank}, 32'h1);
      run(20);

      // Freeze with a capture pending, then reset in the middle of the flash.
      mode = 2'b00;
      run(50);
      en = 1'b0;
      run(3);
      pulse_score(16'h0021);
      run(16);
      chk("frz_tick", {31'b0, scan_tick}, 32'h0);
      en = 1'b1;
      run(22);
      rst_n = 1'b0;
      run(1);
      chk("rst2_disp",  {16'b0, disp_num}, 32'h0);
      chk("rst2_blank", {31'b0, blank}, 32'h1);
      chk("rst2_dig",   {30'b0, dig_sel}, 32'h0);
      rst_n = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 99) < 95);
         rst_n     = ($urandom_range(0, 999) != 0);
         if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
         score_vld = ($urandom_range(0, 29) == 0);
         if (score_vld) score = 16'($urandom);
         if ($urandom_range(0, 19) == 0) timer = 16'($urandom);
         run(1);
      end
      score_vld = 1'b0; rst_n = 1'b1;
      run(2);
      chk("sb_drained", sb_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
